// File: rtl/game_disp_pkg.sv
// Shared constants, FSM encoding and helpers for the game time display.
// Segment patterns are active-low {g..a}.
package game_disp_pkg;

  localparam int CNT_W  = 10;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int SH_W   = BCD_W + CNT_W;

  localparam logic [3:0] ITER_LAST = 4'(CNT_W - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [6:0] seg(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  // One double-dabble step: correct every BCD nibble, then shift.
  function automatic logic [SH_W-1:0] dd_step(
    input logic [SH_W-1:0] s
  );
    logic [SH_W-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[CNT_W+4*i +: 4] >= 4'd5)
        t[CNT_W+4*i +: 4] = t[CNT_W+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/game_time_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD engine.
// One shift per clock; result valid while done is high.
module bin2bcd_seq
  import game_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  state_t            state;
  state_t            state_nxt;
  logic [SH_W-1:0]   shreg;
  logic [3:0]        iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: if (iter == ITER_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
    bcd  = shreg[SH_W-1 -: BCD_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      iter  <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg <= {{BCD_W{1'b0}}, din};
            iter  <= '0;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          shreg <= dd_step(shreg);
          iter  <= iter + 4'd1;
        end
        DONE: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/game_time_display.sv
// Game clock display "SSS.T" on four 7-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on HEX3/HEX2.
module game_time_display
  import game_disp_pkg::*;
(
  input  logic             CLOCK10M,
  input  logic             KEY0,
  input  logic [CNT_W-1:0] count_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic             HEX1_DP,
  output logic             busy,
  output logic             valid
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX_HI_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX_HI_RST = SEG_DIGIT[0];
`endif

  logic [CNT_W-1:0] last_cnt;
  logic             start;
  logic             eng_done;
  logic [BCD_W-1:0] eng_bcd;
  logic [6:0]       h0_nxt;
  logic [6:0]       h1_nxt;
  logic [6:0]       h2_nxt;
  logic [6:0]       h3_nxt;

  // busy stays high through DONE, so start only fires from IDLE
  assign start   = !busy && (count_in != last_cnt);
  assign HEX1_DP = 1'b0;

  bin2bcd_seq u_b2b (
    .clk   (CLOCK10M),
    .rst   (KEY0),
    .start (start),
    .din   (count_in),
    .busy  (busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_comb begin
    h0_nxt = seg(eng_bcd[3:0]);
    h1_nxt = seg(eng_bcd[7:4]);
    h2_nxt = seg(eng_bcd[11:8]);
    h3_nxt = seg(eng_bcd[15:12]);
`ifdef LEADING_ZERO_BLANK_EN
    if (eng_bcd[15:12] == 4'd0) h3_nxt = SEG_BLANK;
    if (eng_bcd[15:8] == 8'd0)  h2_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      last_cnt <= '0;
      bcd_out  <= '0;
      HEX0     <= SEG_DIGIT[0];
      HEX1     <= SEG_DIGIT[0];
      HEX2     <= HEX_HI_RST;
      HEX3     <= HEX_HI_RST;
      valid    <= 1'b0;
    end else begin
      valid <= eng_done;
      if (start) last_cnt <= count_in;
      if (eng_done) begin
        bcd_out <= eng_bcd;
        HEX0    <= h0_nxt;
        HEX1    <= h1_nxt;
        HEX2    <= h2_nxt;
        HEX3    <= h3_nxt;
      end
    end
  end

endmodule

// File: tb/tb_game_time_display.sv
// Self-checking bench for game_time_display: per-cycle model compare
// plus directed literal checks.
module tb_game_time_display;

  logic       CLOCK10M = 1'b0;
  logic       KEY0     = 1'b0;
  logic [9:0] count_in = 10'd0;
  logic [15:0] bcd_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       HEX1_DP, busy, valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  game_time_display dut (
    .CLOCK10M (CLOCK10M),
    .KEY0     (KEY0),
    .count_in (count_in),
    .bcd_out  (bcd_out),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX1_DP  (HEX1_DP),
    .busy     (busy),
    .valid    (valid)
  );

  always #50 CLOCK10M = ~CLOCK10M;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: a conversion takes 11 edges, ignores input while running
  int m_last = 0;
  int m_disp = 0;
  int m_rem  = 0;
  bit m_valid = 0;

  always @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      m_last = 0; m_disp = 0; m_rem = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp  = m_last;
          m_valid = 1;
        end
      end else if (int'(count_in) != m_last) begin
        m_last = int'(count_in);
        m_rem  = 11;
      end
    end
  end

  always @(posedge CLOCK10M) begin
    logic [6:0] h2, h3;
    #1;
    if (valid) n_pulses++;
    h3 = exp_seg(m_disp / 1000);
    h2 = exp_seg((m_disp / 100) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_disp < 1000) h3 = 7'h7F;
    if (m_disp < 100)  h2 = 7'h7F;
`endif
    chk("busy", busy, m_rem > 0);
    chk("valid", valid, m_valid);
    chk("bcd_out", bcd_out, exp_bcd(m_disp));
    chk("HEX0", HEX0, exp_seg(m_disp % 10));
    chk("HEX1", HEX1, exp_seg((m_disp / 10) % 10));
    chk("HEX2", HEX2, h2);
    chk("HEX3", HEX3, h3);
    chk("HEX1_DP", HEX1_DP, 1'b0);
  end

  task automatic set_wait(input int v, input int cyc);
    @(negedge CLOCK10M);
    count_in = 10'(v);
    repeat (cyc) @(negedge CLOCK10M);
  endtask

  initial begin
    int p0;
    #1 KEY0 = 1'b1;
    repeat (3) @(negedge CLOCK10M);
    KEY0 = 1'b0;

    // 1: reset idle with count 0
    repeat (20) @(negedge CLOCK10M);
    chk("t1_pulses", n_pulses, 0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_hex0", HEX0, 7'b1000000);

    // 2: 0 -> 123, latency window
    @(negedge CLOCK10M);
    count_in = 10'd123;
    @(negedge CLOCK10M);
    chk("t2_busy_n", busy, 1'b1);
    repeat (10) @(negedge CLOCK10M);
    chk("t2_busy_n10", busy, 1'b1);
    chk("t2_valid_n10", valid, 1'b0);
    @(negedge CLOCK10M);
    chk("t2_valid_n11", valid, 1'b1);
    chk("t2_busy_n11", busy, 1'b0);
    chk("t2_bcd", bcd_out, 16'h0123);
    chk("t2_hex0", HEX0, 7'b0110000);
    repeat (3) @(negedge CLOCK10M);

    // 3: maximum and thousands rollover
    set_wait(1023, 14);
    chk("t3_1023", bcd_out, 16'h1023);
    set_wait(999, 14);
    chk("t3_999", bcd_out, 16'h0999);
    set_wait(1000, 14);
    chk("t3_1000", bcd_out, 16'h1000);

    // 4: changes during conversion
    p0 = n_pulses;
    set_wait(5, 3);
    count_in = 10'd6;
    repeat (3) @(negedge CLOCK10M);
    count_in = 10'd7;
    repeat (30) @(negedge CLOCK10M);
    chk("t4_pulses", n_pulses - p0, 2);
    chk("t4_bcd", bcd_out, 16'h0007);

    // 5: reset at iteration 4
    @(negedge CLOCK10M);
    count_in = 10'd200;
    repeat (5) @(negedge CLOCK10M);
    chk("t5_busy_pre", busy, 1'b1);
    KEY0 = 1'b1;
    #1;
    chk("t5_bcd_rst", bcd_out, 16'h0000);
    chk("t5_busy_rst", busy, 1'b0);
    chk("t5_hex0_rst", HEX0, 7'b1000000);
    @(negedge CLOCK10M);
    KEY0 = 1'b0;
    repeat (14) @(negedge CLOCK10M);
    chk("t5_bcd_after", bcd_out, 16'h0200);

    // 6: leading zero handling for 5
    set_wait(5, 14);
    chk("t6_bcd", bcd_out, 16'h0005);
    chk("t6_hex0", HEX0, 7'b0010010);
    chk("t6_hex1", HEX1, 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_hex2", HEX2, 7'h7F);
    chk("t6_hex3", HEX3, 7'h7F);
`else
    chk("t6_hex2", HEX2, 7'b1000000);
    chk("t6_hex3", HEX3, 7'b1000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
